// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer: holds the PLL in reset, waits for a stable synchronised lock, then releases sys_rst.
// Latency: lock rise to ready = 2 sync + 1 state entry + LOCK_STABLE_CYCLES clkin cycles; all outputs registered.
// Backpressure: none; relock_req is a one-cycle pulse honoured only in S_RUN and S_FAULT.
// Optional: define PLL_SEQ_AUTO_RELOCK_EN to restart the PLL (instead of faulting) when lock drops in S_RUN.
module pll_lock_sequencer #(
   parameter int RST_HOLD_CYCLES     = 32,
   parameter int LOCK_STABLE_CYCLES  = 1024,
   parameter int LOCK_TIMEOUT_CYCLES = 65536,
   parameter int MAX_RETRIES         = 3
) (
   input  logic       clkin,
   input  logic       reset,
   input  logic       pll_lock,
   input  logic       relock_req,
   output logic       pll_reset,
   output logic       sys_rst,
   output logic       ready,
   output logic       fault,
   output logic [3:0] retry_cnt
);

   // One shared cycle counter, wide enough for the largest per-state duration.
   localparam int MAX_A = (RST_HOLD_CYCLES > LOCK_STABLE_CYCLES) ? RST_HOLD_CYCLES : LOCK_STABLE_CYCLES;
   localparam int MAX_P = (MAX_A > LOCK_TIMEOUT_CYCLES) ? MAX_A : LOCK_TIMEOUT_CYCLES;
   localparam int CW    = (MAX_P > 1) ? $clog2(MAX_P) : 1;

   // The counter reads N-1 during the N-th cycle spent in a state.
   localparam logic [CW-1:0] CNT_MAX      = {CW{1'b1}};
   localparam logic [CW-1:0] CNT_ONE      = CW'(1);
   localparam logic [CW-1:0] RST_LAST     = CW'(RST_HOLD_CYCLES - 1);
   localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [3:0]    RETRY_LIMIT  = 4'(MAX_RETRIES);

   typedef enum logic [2:0] {
      S_RESET,
      S_WAIT_LOCK,
      S_STABLE,
      S_RUN,
      S_FAULT
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]    retry_q, retry_d;
   logic [3:0]    retry_inc;
   logic          lock_meta_q, lock_s_q;
   logic          pll_reset_q, pll_reset_d;
   logic          sys_rst_q, sys_rst_d;
   logic          ready_q, ready_d;
   logic          fault_q, fault_d;

   // Two-flop synchroniser for the asynchronous PLL lock indication.
   always_ff @(posedge clkin) begin
      if (reset) begin
         lock_meta_q <= 1'b0;
         lock_s_q    <= 1'b0;
      end else begin
         lock_meta_q <= pll_lock;
         lock_s_q    <= lock_meta_q;
      end
   end

   // State, counter, retry count and registered Moore outputs.
   always_ff @(posedge clkin) begin
      if (reset) begin
         state_q     <= S_RESET;
         cnt_q       <= '0;
         retry_q     <= '0;
         pll_reset_q <= 1'b1;
         sys_rst_q   <= 1'b1;
         ready_q     <= 1'b0;
         fault_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         retry_q     <= retry_d;
         pll_reset_q <= pll_reset_d;
         sys_rst_q   <= sys_rst_d;
         ready_q     <= ready_d;
         fault_q     <= fault_d;
      end
   end

   // Next-state, retry bookkeeping and saturating per-state cycle counter.
   always_comb begin
      state_d   = state_q;
      retry_d   = retry_q;
      retry_inc = retry_q + 4'd1;
      case (state_q)
         S_RESET: begin
            if (cnt_q == RST_LAST) begin
               state_d = S_WAIT_LOCK;
            end
         end
         S_WAIT_LOCK: begin
            if (lock_s_q) begin
               state_d = S_STABLE;
            end else if (cnt_q == TIMEOUT_LAST) begin
               retry_d = retry_inc;
               state_d = (retry_inc == RETRY_LIMIT) ? S_FAULT : S_RESET;
            end
         end
         S_STABLE: begin
            if (!lock_s_q) begin
               state_d = S_WAIT_LOCK;
            end else if (cnt_q == STABLE_LAST) begin
               state_d = S_RUN;
               retry_d = '0;
            end
         end
         S_RUN: begin
            // An explicit relock request wins over a simultaneous lock loss.
            if (relock_req) begin
               state_d = S_RESET;
               retry_d = '0;
            end else if (!lock_s_q) begin
`ifdef PLL_SEQ_AUTO_RELOCK_EN
               state_d = S_RESET;
`else
               state_d = S_FAULT;
`endif
            end
         end
         S_FAULT: begin
            if (relock_req) begin
               state_d = S_RESET;
               retry_d = '0;
            end
         end
         default: begin
            state_d = S_RESET;
         end
      endcase

      // Every state change restarts the count; otherwise count up and stick at the top.
      if (state_d != state_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_MAX) begin
         cnt_d = cnt_q;
      end else begin
         cnt_d = cnt_q + CNT_ONE;
      end
   end

   // Output decode from the next state so outputs switch on the same edge as the state.
   always_comb begin
      pll_reset_d = 1'b0;
      sys_rst_d   = 1'b1;
      ready_d     = 1'b0;
      fault_d     = 1'b0;
      case (state_d)
         S_RESET: begin
            pll_reset_d = 1'b1;
         end
         S_RUN: begin
            sys_rst_d = 1'b0;
            ready_d   = 1'b1;
         end
         S_FAULT: begin
            pll_reset_d = 1'b1;
            fault_d     = 1'b1;
         end
         default: begin
            pll_reset_d = 1'b0;
         end
      endcase
   end

   assign pll_reset = pll_reset_q;
   assign sys_rst   = sys_rst_q;
   assign ready     = ready_q;
   assign fault     = fault_q;
   assign retry_cnt = retry_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb_pll_lock_sequencer: directed scenarios plus randomised lock/relock/reset traffic.
// Every cycle the DUT outputs are compared with a timestamp-based phase model.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
module tb_pll_lock_sequencer;

   localparam int RST_HOLD = 4;
   localparam int STABLE   = 8;
   localparam int TIMEOUT  = 16;
   localparam int MAXR     = 2;

   logic       clkin = 1'b0;
   logic       reset;
   logic       pll_lock;
   logic       relock_req;
   logic       pll_reset;
   logic       sys_rst;
   logic       ready;
   logic       fault;
   logic [3:0] retry_cnt;

   int checks   = 0;
   int failures = 0;

   pll_lock_sequencer #(
      .RST_HOLD_CYCLES    (RST_HOLD),
      .LOCK_STABLE_CYCLES (STABLE),
      .LOCK_TIMEOUT_CYCLES(TIMEOUT),
      .MAX_RETRIES        (MAXR)
   ) dut (
      .clkin     (clkin),
      .reset     (reset),
      .pll_lock  (pll_lock),
      .relock_req(relock_req),
      .pll_reset (pll_reset),
      .sys_rst   (sys_rst),
      .ready     (ready),
      .fault     (fault),
      .retry_cnt (retry_cnt)
   );

   always #5 clkin = ~clkin;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference model: phase plus the edge at which it was entered; durations are
   // timestamp differences. Lock decisions see pll_lock as sampled two edges earlier.
   localparam int P_RESET = 0, P_WAIT = 1, P_STABLE = 2, P_RUN = 3, P_FAULT = 4;
   int m_phase   = P_RESET;
   int m_entry   = 0;
   int m_edge    = 0;
   int m_retries = 0;
   bit lock_pipe[$];

   function automatic void enter(input int ph);
      m_phase = ph;
      m_entry = m_edge;
   endfunction

   function automatic void model_step();
      bit ls;
      int held;
      m_edge++;
      if (reset) begin
         enter(P_RESET);
         m_retries = 0;
         lock_pipe.delete();
         lock_pipe.push_back(1'b0);
         lock_pipe.push_back(1'b0);
         return;
      end
      ls = lock_pipe.pop_front();
      lock_pipe.push_back(pll_lock);
      held = m_edge - m_entry;
      case (m_phase)
         P_RESET:  if (held == RST_HOLD) enter(P_WAIT);
         P_WAIT: begin
            if (ls) enter(P_STABLE);
            else if (held == TIMEOUT) begin
               m_retries++;
               enter((m_retries == MAXR) ? P_FAULT : P_RESET);
            end
         end
         P_STABLE: begin
            if (!ls) enter(P_WAIT);
            else if (held == STABLE) begin
               enter(P_RUN);
               m_retries = 0;
            end
         end
         P_RUN: begin
            if (relock_req) begin
               m_retries = 0;
               enter(P_RESET);
            end else if (!ls) begin
`ifdef PLL_SEQ_AUTO_RELOCK_EN
               enter(P_RESET);
`else
               enter(P_FAULT);
`endif
            end
         end
         default: begin
            if (relock_req) begin
               m_retries = 0;
               enter(P_RESET);
            end
         end
      endcase
   endfunction

   // One clock cycle: advance the model at the edge, then compare all outputs.
   task automatic tick();
      @(posedge clkin);
      model_step();
      #1;
      check("pll_reset", pll_reset, (m_phase == P_RESET || m_phase == P_FAULT));
      check("sys_rst",   sys_rst,   (m_phase != P_RUN));
      check("ready",     ready,     (m_phase == P_RUN));
      check("fault",     fault,     (m_phase == P_FAULT));
      check("retry_cnt", retry_cnt, m_retries);
   endtask

   initial begin
      int n;
      bit lvl;
      int seg_left;

      reset      = 1'b1;
      pll_lock   = 1'b0;
      relock_req = 1'b0;
      lock_pipe.push_back(1'b0);
      lock_pipe.push_back(1'b0);
      repeat (3) tick();
      check("reset_outs", {pll_reset, sys_rst, ready, fault, retry_cnt}, 8'b1100_0000);

      // Normal bring-up: reset hold length, then lock to ready latency.
      reset = 1'b0;
      n = 0;
      do begin tick(); n++; end while (pll_reset && n < 50);
      check("rst_hold_len", n, RST_HOLD);
      repeat (2) tick();
      pll_lock = 1'b1;
      n = 0;
      do begin tick(); n++; end while (!ready && n < 50);
      check("lock_to_ready", n, 2 + 1 + STABLE);
      check("sysrst_with_ready", sys_rst, 1'b0);

      // Lock loss while running.
      repeat (5) tick();
      pll_lock = 1'b0;
      n = 0;
`ifdef PLL_SEQ_AUTO_RELOCK_EN
      do begin tick(); n++; end while (!pll_reset && n < 20);
      check("loss_to_reset", n, 3);
      check("loss_outs", {sys_rst, ready, fault, retry_cnt}, 7'b100_0000);
      n = 0;
      do begin tick(); n++; end while (pll_reset && n < 20);
      check("loss_rst_hold", n, RST_HOLD);
`else
      do begin tick(); n++; end while (!fault && n < 20);
      check("loss_to_fault", n, 3);
      check("loss_fault_prst", pll_reset, 1'b1);
`endif

      // No lock at all: two attempts, then fault.
      reset = 1'b1;
      tick();
      reset = 1'b0;
      n = 0;
      do begin tick(); n++; end while (pll_reset && n < 50);
      check("att1_hold", n, RST_HOLD);
      n = 0;
      do begin tick(); n++; end while (!pll_reset && n < 50);
      check("att1_timeout", n, TIMEOUT);
      check("att1_retry", retry_cnt, 4'd1);
      n = 0;
      do begin tick(); n++; end while (pll_reset && n < 50);
      check("att2_hold", n, RST_HOLD);
      n = 0;
      do begin tick(); n++; end while (!pll_reset && n < 50);
      check("att2_timeout", n, TIMEOUT);
      check("att2_fault", {fault, retry_cnt}, 5'b1_0010);
      repeat (5) tick();
      check("fault_sticky", {fault, pll_reset, sys_rst, ready}, 4'b1110);

      // Relock from fault restarts the sequence; relock while waiting is ignored.
      relock_req = 1'b1;
      tick();
      relock_req = 1'b0;
      check("relock_outs", {fault, retry_cnt, pll_reset}, 6'b0_0000_1);
      n = 1;
      do begin tick(); n++; end while (pll_reset && n < 50);
      check("relock_hold", n, RST_HOLD + 1);
      relock_req = 1'b1;
      tick();
      relock_req = 1'b0;
      check("relock_ignored", {pll_reset, fault}, 2'b00);

      // One-cycle lock glitch part way through the stable count.
      n = 0;
      do begin
         n++;
         pll_lock = (n == 8) ? 1'b0 : 1'b1;
         tick();
      end while (!ready && n < 100);
      check("glitch_ready_delay", n, 19);

      // Reset pulse while in the stable phase.
      relock_req = 1'b1;
      tick();
      relock_req = 1'b0;
      n = 0;
      do begin tick(); n++; end while (pll_reset && n < 50);
      repeat (3) tick();
      reset = 1'b1;
      tick();
      check("midseq_reset", {pll_reset, sys_rst, ready, fault, retry_cnt}, 8'b1100_0000);
      reset = 1'b0;
      n = 0;
      do begin tick(); n++; end while (pll_reset && n < 50);
      check("restart_hold", n, RST_HOLD);

      // Randomised lock segments with occasional relock requests and resets.
      lvl = 1'b0;
      seg_left = 0;
      for (int i = 0; i < 4000; i++) begin
         if (seg_left == 0) begin
            lvl = ~lvl;
            seg_left = lvl ? $urandom_range(60, 4) : $urandom_range(24, 1);
         end
         pll_lock   = lvl;
         seg_left--;
         relock_req = ($urandom_range(39, 0) == 0);
         reset      = ($urandom_range(299, 0) == 0);
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pll_lock_sequencer.md
PLL_LOCK_SEQUENCER -- requirements
Module: pll_lock_sequencer

Interface
REQ-001 SHALL have parameter RST_HOLD_CYCLES, default 32: number of cycles pll_reset is held high per attempt (min 1).
REQ-002 SHALL have parameter LOCK_STABLE_CYCLES, default 1024: number of consecutive synced-lock cycles required before release (min 1).
REQ-003 SHALL have parameter LOCK_TIMEOUT_CYCLES, default 65536: number of cycles to wait for lock per attempt (min 1).
REQ-004 SHALL have parameter MAX_RETRIES, default 3: number of failed attempts before fault (1..15).
REQ-005 SHALL have port clkin, input, 1 bit: free-running reference clock (PLL input clock, never PLL output); the only clock.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port pll_lock, input, 1 bit: PLL LOCK, asynchronous to clkin.
REQ-008 SHALL have port relock_req, input, 1 bit: single-cycle request to restart the PLL.
REQ-009 SHALL have port pll_reset, output, 1 bit: drives PLL RESET, active-high.
REQ-010 SHALL have port sys_rst, output, 1 bit: active-high reset to logic clocked by the PLL output.
REQ-011 SHALL have port ready, output, 1 bit: PLL locked and stable.
REQ-012 SHALL have port fault, output, 1 bit: retries exhausted.
REQ-013 SHALL have port retry_cnt, output, 4 bits: failed attempts in the current sequence.

Function
REQ-014 SHALL synchronise pll_lock through 2 flops to produce lock_s; all decisions SHALL use lock_s only.
REQ-015 SHALL implement states S_RESET, S_WAIT_LOCK, S_STABLE, S_RUN, S_FAULT; all outputs SHALL be registered Moore functions of state.
REQ-016 S_RESET: pll_reset=1; after exactly RST_HOLD_CYCLES cycles in state, SHALL go to S_WAIT_LOCK.
REQ-017 S_WAIT_LOCK: pll_reset=0; lock_s=1 SHALL go to S_STABLE; after LOCK_TIMEOUT_CYCLES cycles without lock_s, SHALL increment retry_cnt.
REQ-018 On timeout, if the incremented retry_cnt equals MAX_RETRIES the block SHALL go to S_FAULT, else to S_RESET.
REQ-019 S_STABLE: lock_s=0 SHALL return to S_WAIT_LOCK with the timeout counter cleared; LOCK_STABLE_CYCLES consecutive lock_s=1 cycles SHALL go to S_RUN.
REQ-020 S_RUN: ready=1, sys_rst=0, retry_cnt cleared on entry; lock_s=0 handling is per REQ-027.
REQ-021 S_FAULT: fault=1, pll_reset=1, sys_rst=1, ready=0; SHALL leave only on reset or relock_req.
REQ-022 sys_rst=1 and ready=0 in every state except S_RUN; ready and sys_rst SHALL change on the same edge.
REQ-023 relock_req in S_RUN or S_FAULT SHALL go to S_RESET, clearing retry_cnt and fault; relock_req SHALL be ignored in other states.
REQ-024 If relock_req and lock_s=0 occur in the same S_RUN cycle, relock_req SHALL take priority.
REQ-025 Every state entry SHALL clear the shared cycle counter; the counter SHALL be sized by $clog2 of the largest parameter and SHALL saturate, never wrap.

Reset
REQ-026 On reset=1 at a clkin edge: state=S_RESET, counter=0, sync flops=0, pll_reset=1, sys_rst=1, ready=0, fault=0, retry_cnt=0; this SHALL apply mid-sequence with no residual state.

Configuration
REQ-027 Macro PLL_SEQ_AUTO_RELOCK_EN: when defined, lock_s=0 in S_RUN SHALL go to S_RESET without touching retry_cnt; when undefined, lock_s=0 in S_RUN SHALL go to S_FAULT.

Verification (RST_HOLD=4, STABLE=8, TIMEOUT=16, MAX_RETRIES=2)
REQ-028 Lock rises 2 cycles after pll_reset falls and stays high -> pll_reset high exactly 4 cycles after reset release; ready=1 and sys_rst=0 on the same edge, 2+8 cycles after lock edge plus state-entry cycle.
REQ-029 pll_lock held 0 -> two pll_reset pulses of 4 cycles each with 16-cycle waits; retry_cnt 1 then 2; fault=1 with pll_reset=1 thereafter.
REQ-030 Lock glitch low for 1 cycle at stable count 5 -> back to S_WAIT_LOCK, full 8-cycle stable count restarts, ready delayed accordingly.
REQ-031 In S_RUN drop lock -> with macro: sys_rst=1, ready=0, new 4-cycle pll_reset pulse, retry_cnt=0; without: fault=1.
REQ-032 In S_FAULT pulse relock_req -> fault=0, retry_cnt=0, pll_reset pulse restarts; relock_req in S_WAIT_LOCK ignored.
REQ-033 Assert reset for 1 cycle during S_STABLE -> all outputs return to reset values next edge, sequence restarts from S_RESET.
